// File: rtl/ps2_cmd_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ps2_cmd_decoder: PS/2 scan code -> 4-bit command, synchronized, filtered,  |
// | buffered in a FIFO. Optional macro HEX_LETTERS_EN adds A-F letter keys.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ps2_cmd_decoder #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] scan_code,
   input  logic       frame_done,
   output logic [3:0] cmd,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   output logic [3:0] mode,
   output logic       err_unknown,
   output logic       overflow
);

   localparam int             AW       = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]    FULL_CNT = (AW+1)'(FIFO_DEPTH);

   logic             s1, s2, s3;
   logic             evt, code_new;
   logic [7:0]       code_q, last_code;
   logic             new_q;
   logic             hit;
   logic [3:0]       dec_cmd;
   logic [3:0]       mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic             full, pop, wr_req, wr_en;

   assign evt      = s2 & ~s3;
   // scan_code is stable around frame_done, so it is sampled without synchronizing
   assign code_new = (scan_code != 8'hFF) && (scan_code != last_code);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1        <= 1'b0;
         s2        <= 1'b0;
         s3        <= 1'b0;
         new_q     <= 1'b0;
         code_q    <= 8'hFF;
         last_code <= 8'hFF;
      end else begin
         s1    <= frame_done;
         s2    <= s1;
         s3    <= s2;
         new_q <= evt & code_new;
         if (evt)
            code_q <= scan_code;
         if (evt && code_new)
            last_code <= scan_code;
      end
   end

   always_comb begin
      hit     = 1'b1;
      dec_cmd = 4'd0;
      case (code_q)
         8'h45: dec_cmd = 4'd0;
         8'h16: dec_cmd = 4'd1;
         8'h1E: dec_cmd = 4'd2;
         8'h26: dec_cmd = 4'd3;
         8'h25: dec_cmd = 4'd4;
         8'h2E: dec_cmd = 4'd5;
         8'h36: dec_cmd = 4'd6;
         8'h3D: dec_cmd = 4'd7;
         8'h3E: dec_cmd = 4'd8;
         8'h46: dec_cmd = 4'd9;
`ifdef HEX_LETTERS_EN
         8'h1C: dec_cmd = 4'd10;
         8'h32: dec_cmd = 4'd11;
         8'h21: dec_cmd = 4'd12;
         8'h23: dec_cmd = 4'd13;
         8'h24: dec_cmd = 4'd14;
         8'h2B: dec_cmd = 4'd15;
`endif
         default: hit = 1'b0;
      endcase
   end

   assign full      = (count == FULL_CNT);
   assign cmd_valid = (count != '0);
   assign cmd       = mem[rd_ptr];
   assign pop       = cmd_valid & cmd_ready;
   assign wr_req    = new_q & hit;
   // a pop on the same edge frees the slot, so a full FIFO still accepts
   assign wr_en     = wr_req & (~full | pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++)
            mem[i] <= 4'd0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         mode        <= 4'd0;
         err_unknown <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         err_unknown <= new_q & ~hit;
         if (wr_req && full && !pop)
            overflow <= 1'b1;
         if (wr_en) begin
            mem[wr_ptr] <= dec_cmd;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            mode   <= cmd;
         end
         case ({wr_en, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ps2_cmd_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ps2_cmd_decoder: directed and random frames against a queue model.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ps2_cmd_decoder;

   localparam int FIFO_DEPTH = 4;

   logic       clk, rst;
   logic [7:0] scan_code;
   logic       frame_done;
   logic [3:0] cmd;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] mode;
   logic       err_unknown;
   logic       overflow;

   ps2_cmd_decoder #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .scan_code   (scan_code),
      .frame_done  (frame_done),
      .cmd         (cmd),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .mode        (mode),
      .err_unknown (err_unknown),
      .overflow    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [3:0] q[$];
   logic [7:0] last_m = 8'hFF;
   logic [3:0] mode_m = 4'd0;
   logic       ovf_m  = 1'b0;

   logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                    8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
   logic [7:0] hex_codes   [6]  = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
   logic [7:0] pool        [20] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                                    8'h3D, 8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23,
                                    8'h24, 8'h2B, 8'hFF, 8'h5A, 8'hF0, 8'h12};

   function automatic int lookup(input logic [7:0] c);
      for (int i = 0; i < 10; i++)
         if (digit_codes[i] == c) return i;
`ifdef HEX_LETTERS_EN
      for (int i = 0; i < 6; i++)
         if (hex_codes[i] == c) return 10 + i;
`endif
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_reset();
      chk("rst_cmd", {4'd0, cmd}, 8'd0);
      chk("rst_valid", {7'd0, cmd_valid}, 8'd0);
      chk("rst_mode", {4'd0, mode}, 8'd0);
      chk("rst_err", {7'd0, err_unknown}, 8'd0);
      chk("rst_ovf", {7'd0, overflow}, 8'd0);
   endtask

   task automatic model_reset();
      q.delete();
      last_m = 8'hFF;
      mode_m = 4'd0;
      ovf_m  = 1'b0;
   endtask

   // One keyboard frame; E0 is the first posedge after frame_done rises.
   task automatic frame(input logic [7:0] code, input int hold, input bit pop_e3);
      int  exp_cmd;
      bit  is_new, unk;
      exp_cmd = lookup(code);
      is_new  = (code != 8'hFF) && (code != last_m);
      if (is_new) last_m = code;
      unk = is_new && (exp_cmd < 0);
      @(negedge clk);
      scan_code  = code;
      frame_done = 1'b1;
      for (int k = 0; k < hold + 5; k++) begin
         @(negedge clk);
         if (k == hold - 1) frame_done = 1'b0;
         if (k == 2) begin
            chk("pre_valid", {7'd0, cmd_valid}, {7'd0, q.size() > 0});
            if (pop_e3) cmd_ready = 1'b1;
         end
         if (k == 3) begin
            cmd_ready = 1'b0;
            if (pop_e3 && q.size() > 0) mode_m = q.pop_front();
            if (is_new && exp_cmd >= 0) begin
               if (q.size() < FIFO_DEPTH) q.push_back(4'(exp_cmd));
               else ovf_m = 1'b1;
            end
            chk("err_pulse", {7'd0, err_unknown}, {7'd0, unk});
            chk("valid", {7'd0, cmd_valid}, {7'd0, q.size() > 0});
            if (q.size() > 0) chk("head", {4'd0, cmd}, {4'd0, q[0]});
            chk("ovf", {7'd0, overflow}, {7'd0, ovf_m});
            chk("mode", {4'd0, mode}, {4'd0, mode_m});
         end
         if (k == 4) chk("err_end", {7'd0, err_unknown}, 8'd0);
      end
   endtask

   task automatic pop_one();
      @(negedge clk);
      chk("pop_valid", {7'd0, cmd_valid}, {7'd0, q.size() > 0});
      if (q.size() > 0) chk("pop_cmd", {4'd0, cmd}, {4'd0, q[0]});
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      if (q.size() > 0) mode_m = q.pop_front();
      chk("pop_mode", {4'd0, mode}, {4'd0, mode_m});
      chk("post_valid", {7'd0, cmd_valid}, {7'd0, q.size() > 0});
      chk("post_ovf", {7'd0, overflow}, {7'd0, ovf_m});
   endtask

   initial begin
      rst        = 1'b1;
      scan_code  = 8'hFF;
      frame_done = 1'b0;
      cmd_ready  = 1'b0;
      repeat (3) @(negedge clk);
      check_reset();
      rst = 1'b0;

      // single key, then consume it
      frame(8'h1E, 10, 1'b0);
      pop_one();

      // repeated key filtered, new key accepted
      frame(8'h16, 10, 1'b0);
      frame(8'h16, 10, 1'b0);
      frame(8'h45, 10, 1'b0);
      pop_one();
      pop_one();
      pop_one();

      // overflow on fifth distinct digit, then drain
      frame(8'h26, 10, 1'b0);
      frame(8'h25, 10, 1'b0);
      frame(8'h2E, 10, 1'b0);
      frame(8'h36, 10, 1'b0);
      frame(8'h3D, 10, 1'b0);
      repeat (5) pop_one();

      // asynchronous reset in mid-cycle with data queued
      frame(8'h3E, 10, 1'b0);
      frame(8'h46, 10, 1'b0);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 check_reset();
      model_reset();
      @(negedge clk);
      rst = 1'b0;

      // full FIFO with pop on the decode edge
      frame(8'h16, 10, 1'b0);
      frame(8'h1E, 10, 1'b0);
      frame(8'h26, 10, 1'b0);
      frame(8'h25, 10, 1'b0);
      frame(8'h2E, 10, 1'b1);
      repeat (4) pop_one();

      // letter key: mapped or unknown depending on build
      frame(8'h1C, 10, 1'b0);
      frame(8'hFF, 10, 1'b0);
      pop_one();

      // random mix of frames and pops
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 2) != 0) begin
            logic [7:0] c;
            c = pool[$urandom_range(0, 19)];
            if ($urandom_range(0, 4) == 0) c = last_m;
            frame(c, int'($urandom_range(3, 12)), 1'b0);
         end else begin
            pop_one();
         end
      end
      repeat (5) pop_one();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
